// File: rtl/vram_pattern_writer.sv
// VRAM test-pattern writer: stands in for the CPU during HDMI bring-up and streams one grayscale
// pixel per accepted transfer across a full H_ACTIVE x V_ACTIVE frame starting at BASE_ADDR.
module vram_pattern_writer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0020_0000,
  parameter int unsigned       H_ACTIVE     = 320,
  parameter int unsigned       V_ACTIVE     = 180,
  parameter int unsigned       CHECKER_LOG2 = 3
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] fg,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned   YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DATA_W-1:0] lin_q, lin_d;
  logic [2:0]        mode_q, mode_d;
  logic [DATA_W-1:0] fg_q, fg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // lin is the low DATA_W bits of y*H_ACTIVE + x, kept as a wrapping counter.
  function automatic logic [DATA_W-1:0] pattern(input logic [2:0]        m,
                                                input logic [DATA_W-1:0] f,
                                                input logic [XW-1:0]     px,
                                                input logic [YW-1:0]     py,
                                                input logic [DATA_W-1:0] lin);
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    cx = px >> CHECKER_LOG2;
    cy = py >> CHECKER_LOG2;
    case (m)
      3'd1:    pattern = {DATA_W{1'b1}} - DATA_W'(px);
      3'd2:    pattern = DATA_W'(py);
      3'd3:    pattern = (cx[0] ^ cy[0]) ? '0 : f;
      3'd4:    pattern = lin;
      default: pattern = f;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lin_d   = lin_q;
    mode_d  = mode_q;
    fg_d    = fg_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = wr_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          fg_d    = fg;
          x_d     = '0;
          y_d     = '0;
          lin_d   = '0;
          addr_d  = BASE_ADDR;
          data_d  = pattern(mode, fg, '0, '0, '0);
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (wr_ready) begin
          if (x_q == XLast && y_q == YLast) begin
            // addr/data keep the last pixel through DONE and IDLE
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            if (x_q == XLast) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            lin_d  = lin_q + 1'b1;
            addr_d = addr_q + 1'b1;
            data_d = pattern(mode_q, fg_q, x_d, y_d, lin_d);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      lin_q   <= '0;
      mode_q  <= '0;
      fg_q    <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lin_q   <= lin_d;
      mode_q  <= mode_d;
      fg_q    <= fg_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_en = wr_en_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_vram_pattern_writer.sv
// Bench for vram_pattern_writer: a small-frame instance under random stimulus checked every cycle
// against a frame-level model, plus a full-size default instance running one gradient frame.
module tb_vram_pattern_writer;

  localparam int unsigned SH   = 40;
  localparam int unsigned SV   = 30;
  localparam int unsigned SN   = SH * SV;
  localparam int unsigned BH   = 320;
  localparam int unsigned BV   = 180;
  localparam int unsigned BN   = BH * BV;
  localparam int unsigned CL   = 3;
  localparam logic [31:0] BASE = 32'h0020_0000;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel value straight from the pattern definitions.
  function automatic logic [7:0] pat(input int m, input logic [7:0] f, input int x, input int y,
                                     input int h);
    int v;
    case (m)
      1:       v = 255 - x;
      2:       v = y;
      3:       v = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 0 : int'(f);
      4:       v = y * h + x;
      default: v = int'(f);
    endcase
    return v[7:0];
  endfunction

  // ---------------- small instance ----------------
  logic        s_rst_n, s_start, s_rdy;
  logic [2:0]  s_mode;
  logic [7:0]  s_fg, s_data;
  logic [31:0] s_addr;
  logic        s_wr_en, s_busy, s_done;

  vram_pattern_writer #(
    .ADDR_W(32), .DATA_W(8), .BASE_ADDR(BASE), .H_ACTIVE(SH), .V_ACTIVE(SV), .CHECKER_LOG2(CL)
  ) u_small (
    .clk_pix(clk_pix), .rst_n(s_rst_n), .start(s_start), .mode(s_mode), .fg(s_fg),
    .wr_ready(s_rdy), .wr_en(s_wr_en), .addr(s_addr), .data(s_data), .busy(s_busy),
    .done(s_done)
  );

  // ---------------- full-size instance ----------------
  logic        b_rst_n, b_start, b_rdy;
  logic [2:0]  b_mode;
  logic [7:0]  b_fg, b_data;
  logic [31:0] b_addr;
  logic        b_wr_en, b_busy, b_done;

  vram_pattern_writer u_big (
    .clk_pix(clk_pix), .rst_n(b_rst_n), .start(b_start), .mode(b_mode), .fg(b_fg),
    .wr_ready(b_rdy), .wr_en(b_wr_en), .addr(b_addr), .data(b_data), .busy(b_busy),
    .done(b_done)
  );

  // Model state: describes the outputs expected at the next falling edge.
  bit          m_active = 0;
  bit          m_done   = 0;
  int          m_k      = 0;
  int          m_mode   = 0;
  logic [7:0]  m_fg     = '0;
  logic [31:0] m_haddr  = BASE;
  logic [7:0]  m_hdata  = '0;
  int          frames_done = 0;
  int          xfers       = 0;
  logic [7:0]  acc [int unsigned];

  always @(negedge clk_pix) begin
    logic [31:0] ea;
    logic [7:0]  ed;
    bit          was_done;
    if (!s_rst_n) begin
      m_active = 0;
      m_done   = 0;
      m_haddr  = BASE;
      m_hdata  = '0;
      check("s_reset", 64'({s_wr_en, s_busy, s_done, s_addr, s_data}), 64'({3'b000, BASE, 8'h00}));
    end else begin
      if (m_active) begin
        ea = BASE + m_k;
        ed = pat(m_mode, m_fg, m_k % SH, m_k / SH, SH);
      end else begin
        ea = m_haddr;
        ed = m_hdata;
      end
      check("s_cycle", 64'({s_wr_en, s_busy, s_done, s_addr, s_data}),
            64'({m_active, m_active, m_done, ea, ed}));
      if (s_wr_en && s_rdy) begin
        acc[s_addr] = s_data;
        xfers++;
      end
      was_done = m_done;
      m_done   = 0;
      if (m_active) begin
        if (s_rdy) begin
          m_k++;
          if (m_k == SN) begin
            m_active = 0;
            m_done   = 1;
            m_haddr  = ea;
            m_hdata  = ed;
            frames_done++;
          end
        end
      end else if (!was_done && s_start) begin
        m_active = 1;
        m_k      = 0;
        m_mode   = int'(s_mode);
        m_fg     = s_fg;
        acc.delete();
        xfers = 0;
      end
    end
  end

  bit rdy_rand = 0;

  task automatic tick();
    @(posedge clk_pix);
    #1;
    s_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_frame(input logic [2:0] m, input logic [7:0] f);
    s_mode  = m;
    s_fg    = f;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_mode  = 3'($urandom_range(0, 7));
    s_fg    = 8'($urandom);
  endtask

  // Returns in the cycle where done is expected high.
  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!m_done && cycles < 5 * SN);
    if (!m_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL s_frame_timeout: got no frame end, expected one within %0d cycles", 5 * SN);
    end
  endtask

  task automatic check_acc(input string name, input logic [31:0] a, input logic [7:0] exp);
    check(name, 64'(acc.exists(a) ? acc[a] : 8'hxx), 64'(exp));
  endtask

  task automatic run_small();
    int cyc;
    int fd0;
    int guard;
    s_rst_n = 1'b1; s_start = 1'b0; s_mode = '0; s_fg = '0; s_rdy = 1'b1;
    #2 s_rst_n = 1'b0;
    repeat (3) tick();
    s_rst_n = 1'b1;
    repeat (2) tick();

    // Gradient, no backpressure.
    start_frame(3'd1, 8'h33);
    wait_frame(cyc);
    check("s1_cycles", 64'(cyc), 64'(SN));
    check("s1_xfers", 64'(xfers), 64'(SN));
    check_acc("s1_first", 32'h0020_0000, 8'hFF);
    check_acc("s1_eol", 32'h0020_0027, 8'hD8);
    check_acc("s1_line1", 32'h0020_0028, 8'hFF);
    check_acc("s1_last", 32'h0020_04AF, 8'hD8);
    repeat (3) tick();

    // Same gradient under random backpressure.
    rdy_rand = 1;
    start_frame(3'd1, 8'h00);
    wait_frame(cyc);
    check("s2_xfers", 64'(xfers), 64'(SN));
    check_acc("s2_first", 32'h0020_0000, 8'hFF);
    check_acc("s2_eol", 32'h0020_0027, 8'hD8);
    check_acc("s2_last", 32'h0020_04AF, 8'hD8);
    repeat (2) tick();

    // Checkerboard.
    start_frame(3'd3, 8'hAA);
    wait_frame(cyc);
    for (int i = 0; i < 8; i++) check_acc("s3_row0", BASE + i, 8'hAA);
    check_acc("s3_x8y0", BASE + 32'd8, 8'h00);
    check_acc("s3_x0y8", BASE + 32'd320, 8'h00);
    check_acc("s3_x8y8", BASE + 32'd328, 8'hAA);
    tick();

    // Vertical gradient, then address ramp with start held across DONE and IDLE.
    rdy_rand = 0;
    start_frame(3'd2, 8'h11);
    wait_frame(cyc);
    check_acc("s4_lastline", 32'h0020_0488, 8'h1D);
    check_acc("s4_lastpix", 32'h0020_04AF, 8'h1D);
    s_mode  = 3'd4;
    s_start = 1'b1;
    tick();
    tick();
    s_start = 1'b0;
    s_mode  = 3'd0;
    wait_frame(cyc);
    check("s4_ramp_cycles", 64'(cyc), 64'(SN));
    check_acc("s4_ramp_100", 32'h0020_0100, 8'h00);
    check_acc("s4_ramp_1ff", 32'h0020_01FF, 8'hFF);
    repeat (2) tick();

    // start/mode/fg noise during a gradient frame.
    fd0 = frames_done;
    start_frame(3'd1, 8'h44);
    repeat (100) tick();
    s_start = 1'b1; s_mode = 3'd0; s_fg = 8'h00;
    tick();
    for (int i = 0; i < 200; i++) begin
      s_start = 1'($urandom_range(0, 1));
      s_mode  = 3'($urandom_range(0, 7));
      s_fg    = 8'($urandom);
      tick();
    end
    s_start = 1'b0;
    wait_frame(cyc);
    check("s5_frames", 64'(frames_done - fd0), 64'd1);
    check("s5_xfers", 64'(xfers), 64'(SN));
    check_acc("s5_eol", 32'h0020_0027, 8'hD8);
    repeat (4) tick();

    // Undefined mode falls back to solid.
    rdy_rand = 1;
    start_frame(3'd7, 8'h6C);
    wait_frame(cyc);
    check_acc("s5b_first", BASE, 8'h6C);
    check_acc("s5b_last", 32'h0020_04AF, 8'h6C);
    check_acc("s5b_rand", BASE + 32'($urandom_range(0, SN - 1)), 8'h6C);
    repeat (2) tick();

    // Asynchronous reset at pixel 1000.
    rdy_rand = 0;
    fd0 = frames_done;
    start_frame(3'd1, 8'h00);
    guard = 0;
    while (m_k != 1000 && guard < 2 * SN) begin
      tick();
      guard++;
    end
    check("s6_reached_1000", 64'(s_addr), 64'(BASE + 32'd1000));
    s_rst_n = 1'b0;
    #1;
    check("s6_async", 64'({s_wr_en, s_busy, s_done, s_addr, s_data}), 64'({3'b000, BASE, 8'h00}));
    tick();
    tick();
    s_rst_n = 1'b1;
    repeat (3) tick();
    check("s6_no_done", 64'(frames_done - fd0), 64'd0);
    start_frame(3'd1, 8'h00);
    wait_frame(cyc);
    check("s6_restart_cycles", 64'(cyc), 64'(SN));
    check_acc("s6_restart_first", BASE, 8'hFF);
    repeat (2) tick();
  endtask

  task automatic run_big();
    b_rst_n = 1'b1; b_start = 1'b0; b_mode = 3'd1; b_fg = 8'h5A; b_rdy = 1'b1;
    #2 b_rst_n = 1'b0;
    #1;
    check("big_reset", 64'({b_wr_en, b_busy, b_done, b_addr, b_data}), 64'({3'b000, BASE, 8'h00}));
    repeat (2) @(posedge clk_pix);
    #1 b_rst_n = 1'b1;
    @(posedge clk_pix);
    #1 b_start = 1'b1;
    @(posedge clk_pix);
    #1 b_start = 1'b0;
    b_mode = 3'd0;
    b_fg   = 8'h00;
    for (int k = 0; k < int'(BN); k++) begin
      @(negedge clk_pix);
      check("big_pixel", 64'({b_wr_en, b_busy, b_done, b_addr, b_data}),
            64'({3'b110, BASE + 32'(k), pat(1, 8'h00, k % BH, k / BH, BH)}));
      if (k == 0)       check("big_first", 64'({b_addr, b_data}), 64'({32'h0020_0000, 8'hFF}));
      if (k == 319)     check("big_eol", 64'({b_addr, b_data}), 64'({32'h0020_013F, 8'hC0}));
      if (k == 320)     check("big_line1", 64'({b_addr, b_data}), 64'({32'h0020_0140, 8'hFF}));
      if (k == BN - 1)  check("big_last_addr", 64'(b_addr), 64'h0020_E0FF);
    end
    @(negedge clk_pix);
    check("big_done", 64'({b_wr_en, b_busy, b_done, b_addr}), 64'({3'b001, 32'h0020_E0FF}));
    @(negedge clk_pix);
    check("big_idle", 64'({b_wr_en, b_busy, b_done, b_addr}), 64'({3'b000, 32'h0020_E0FF}));
  endtask

  initial begin
    fork
      run_small();
      run_big();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_pattern_writer.md
Name: vram_pattern_writer

Overview:
Parametrised VRAM test-pattern writer that stands in for the CPU during HDMI bring-up. It drives the VRAM write port of the HDMI controller, one pixel per accepted transfer, across a full H_ACTIVE x V_ACTIVE frame starting at BASE_ADDR. The block selects among several grayscale patterns and supports a start/busy/done handshake and write backpressure (wr_ready). It can re-run frames without a reset.

Parameters:
ADDR_W, 32, width of addr output
DATA_W, 8, pixel data width (grayscale, R=G=B)
BASE_ADDR, 32'h0020_0000, VRAM address of pixel (0,0)
H_ACTIVE, 320, pixels per line (>=2)
V_ACTIVE, 180, lines per frame (>=2)
CHECKER_LOG2, 3, checkerboard square size = 2**CHECKER_LOG2 pixels

Ports:
clk_pix  input  1  pixel clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to write one frame
mode  input  3  pattern select, sampled with start
fg  input  DATA_W  foreground level, sampled with start
wr_ready  input  1  VRAM accepts current write this cycle
wr_en  output  1  write request; transfer = wr_en & wr_ready
addr  output  ADDR_W  VRAM write address
data  output  DATA_W  VRAM write data
busy  output  1  frame in progress
done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_en=0, addr=BASE_ADDR, data=0, busy=0, done=0, x=0, y=0. Takes effect immediately, including mid-frame; the frame is abandoned.
- All outputs registered. addr kept as running counter (no multiplier): addr = BASE_ADDR + y*H_ACTIVE + x.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: start=1 at edge N -> latch mode/fg, x=0, y=0; at N+1: state=RUN, busy=1, wr_en=1, addr=BASE_ADDR, data=pattern(0,0).
- RUN: on transfer, advance x; if x==H_ACTIVE-1 then x=0, y=y+1; addr+1; data=pattern(next x,y), valid the next cycle. wr_en stays 1 back-to-back (one pixel/cycle at wr_ready=1).
- Stall: while wr_en=1 and wr_ready=0, addr/data/wr_en held stable.
- Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) transferred -> next cycle: state=DONE, wr_en=0, busy=0, done=1; addr/data hold last values. Following cycle: state=IDLE, done=0.
- Exactly H_ACTIVE*V_ACTIVE transfers per frame; no address beyond BASE_ADDR+H_ACTIVE*V_ACTIVE-1 is driven with wr_en=1.
- start while busy or in DONE: ignored. mode/fg changes during RUN: ignored (latched copies used).
- start in IDLE in the cycle after done: accepted, new frame.
- Patterns (width DATA_W, truncation mod 2**DATA_W):
  0 solid: fg
  1 horizontal gradient: all-ones minus x
  2 vertical gradient: y
  3 checkerboard: ((x>>CHECKER_LOG2) ^ (y>>CHECKER_LOG2)) bit0 ? 0 : fg
  4 address ramp: low DATA_W bits of (y*H_ACTIVE + x)
  5-7: treated as mode 0.

Test Plan:
1. Defaults, mode=1, wr_ready=1, start pulse -> wr_en from next cycle for 57600 consecutive cycles; first write addr 0x0020_0000 data 0xFF; addr 0x0020_013F data 0xC0; addr 0x0020_0140 data 0xFF; last addr 0x0020_E0FF; done=1 exactly one cycle after last, busy=0 then.
2. mode=1 with pseudo-random wr_ready (~50%) -> addr/data/wr_en constant through every stall; accepted sequence identical to scenario 1; 57600 transfers, single done pulse.
3. mode=3, fg=0xAA, CHECKER_LOG2=3 -> (x=0..7,y=0)=0xAA; (x=8,y=0)=0x00; (x=0,y=8)=0x00; (x=8,y=8)=0xAA.
4. mode=2 then mode=4 frames back-to-back (start in cycle after done) -> mode 2: line y=179 data 0xB3; mode 4: addr 0x0020_0100 data 0x00, 0x0020_01FF data 0xFF.
5. start and mode=0 pulsed mid-frame of a mode-1 run -> ignored; pattern stays gradient, no restart, one done pulse; mode=7 frame -> every pixel = fg.
6. rst_n low at pixel 1000 -> same-edge-independent: wr_en=0, busy=0, addr=0x0020_0000, data=0 immediately; no done; subsequent start restarts at 0x0020_0000.
